// File: rtl/ff_input_cond.sv
// Cabinet switch conditioner: 2-flop sync, polarity mask, per-channel debounce,
// and fixed-width rate-limited pulses on coin channels; level + edge strobes elsewhere.
module ff_input_cond #(
    parameter int             NCH        = 10,
    parameter int             CNT_W      = 16,
    parameter int             DEBOUNCE   = 12000,
    parameter logic [NCH-1:0] INVERT     = '0,
    parameter logic [NCH-1:0] COIN_MASK  = '0,
    parameter int             COIN_PULSE = 6000,
    parameter int             COIN_GAP   = 12000,
    parameter int             PW_W       = 16
) (
    input  logic           clk12m,
    input  logic           reset,
    input  logic [NCH-1:0] sw_in,
    output logic [NCH-1:0] sw_out,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall,
    output logic [NCH-1:0] coin_drop
);

    typedef enum logic [1:0] {
        C_IDLE  = 2'd0,
        C_PULSE = 2'd1,
        C_GAP   = 2'd2
    } coin_state_e;

    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE - 1);
    localparam logic [PW_W-1:0]  PULSE_LAST = PW_W'(COIN_PULSE - 1);
    localparam logic [PW_W-1:0]  GAP_LAST   = PW_W'((COIN_GAP > 0) ? (COIN_GAP - 1) : 0);
    localparam bit               HAS_GAP    = (COIN_GAP > 0);

    logic [NCH-1:0]   sync1_q;
    logic [NCH-1:0]   sync2_q;
    logic [NCH-1:0]   stable_q;
    logic [NCH-1:0]   stable_d;
    logic [NCH-1:0]   rise_q;
    logic [NCH-1:0]   rise_d;
    logic [NCH-1:0]   fall_q;
    logic [NCH-1:0]   fall_d;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];

    // Counter only advances while sync2 disagrees with the accepted state, so
    // any reversion before the terminal count discards the candidate change.
    always_comb begin
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == DB_LAST) begin
                cnt_d[i]    = '0;
                stable_d[i] = sync2_q[i];
                rise_d[i]   = sync2_q[i];
                fall_d[i]   = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk12m) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sw_in ^ INVERT;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        if (COIN_MASK[g]) begin : g_coin
            coin_state_e     state_q;
            coin_state_e     state_d;
            logic [PW_W-1:0] pc_q;
            logic [PW_W-1:0] pc_d;

            always_ff @(posedge clk12m) begin
                if (reset) begin
                    state_q <= C_IDLE;
                    pc_q    <= '0;
                end else begin
                    state_q <= state_d;
                    pc_q    <= pc_d;
                end
            end

            // The switch level is ignored here; only a debounced rise starts a pulse.
            always_comb begin
                state_d = state_q;
                pc_d    = pc_q;
                case (state_q)
                    C_IDLE: begin
                        if (rise_q[g]) begin
                            state_d = C_PULSE;
                            pc_d    = '0;
                        end
                    end
                    C_PULSE: begin
                        if (pc_q == PULSE_LAST) begin
                            pc_d    = '0;
                            state_d = HAS_GAP ? C_GAP : C_IDLE;
                        end else begin
                            pc_d = pc_q + PW_W'(1);
                        end
                    end
                    C_GAP: begin
                        if (pc_q == GAP_LAST) begin
                            pc_d    = '0;
                            state_d = C_IDLE;
                        end else begin
                            pc_d = pc_q + PW_W'(1);
                        end
                    end
                    default: begin
                        state_d = C_IDLE;
                        pc_d    = '0;
                    end
                endcase
            end

            assign sw_out[g]    = (state_q == C_PULSE);
            assign coin_drop[g] = rise_q[g] & (state_q != C_IDLE);
        end else begin : g_level
            assign sw_out[g]    = stable_q[g];
            assign coin_drop[g] = 1'b0;
        end
    end

endmodule

// File: tb/tb_ff_input_cond.sv
// Bench for ff_input_cond: directed switch sequences checked against a
// timestamp/history model every cycle, plus literal latency checkpoints.
module tb_ff_input_cond;

    localparam int             NCH = 4;
    localparam int             DB  = 4;
    localparam int             P   = 3;
    localparam int             G   = 5;
    localparam logic [NCH-1:0] INV = 4'b0010;
    localparam logic [NCH-1:0] CM  = 4'b1000;

    logic           clk;
    logic           reset;
    logic [NCH-1:0] sw_in;
    logic [NCH-1:0] sw_out;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
    logic [NCH-1:0] coin_drop;

    int total = 0;
    int bad   = 0;

    ff_input_cond #(
        .NCH(NCH), .CNT_W(16), .DEBOUNCE(DB), .INVERT(INV), .COIN_MASK(CM),
        .COIN_PULSE(P), .COIN_GAP(G), .PW_W(16)
    ) dut (
        .clk12m(clk), .reset(reset), .sw_in(sw_in),
        .sw_out(sw_out), .rise(rise), .fall(fall), .coin_drop(coin_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a change is accepted once the last DB sync2 samples all hold the
    // new value; a coin pulse occupies edges [start, start+P) and locks out
    // new coins until start+P+G.
    logic [NCH-1:0] m_s1, m_s2, m_stable, m_rise, m_fall;
    logic [DB-1:0]  m_hist [NCH];
    int             m_pstart [NCH];
    logic [NCH-1:0] e_sw, e_rise, e_fall, e_cd;
    bit             m_valid = 1'b0;
    int             cyc = 0;

    function automatic bit busy(input int ps, input int t);
        return (t >= ps) && (t < ps + P + G);
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_fall = '0;
            e_sw = '0; e_rise = '0; e_fall = '0; e_cd = '0;
            for (int c = 0; c < NCH; c++) begin
                m_hist[c]   = '0;
                m_pstart[c] = -1000;
            end
            m_valid = 1'b1;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (CM[c] && m_rise[c] && !busy(m_pstart[c], cyc - 1))
                    m_pstart[c] = cyc;
                m_hist[c] = {m_hist[c][DB-2:0], m_s2[c]};
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                if (!m_stable[c] && (&m_hist[c])) begin
                    m_stable[c] = 1'b1;
                    m_rise[c]   = 1'b1;
                end else if (m_stable[c] && !(|m_hist[c])) begin
                    m_stable[c] = 1'b0;
                    m_fall[c]   = 1'b1;
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = sw_in[c] ^ INV[c];
                e_sw[c] = CM[c] ? ((cyc >= m_pstart[c]) && (cyc < m_pstart[c] + P))
                                : m_stable[c];
                e_cd[c] = CM[c] & m_rise[c] & busy(m_pstart[c], cyc);
            end
            e_rise = m_rise;
            e_fall = m_fall;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            total += 4;
            if (sw_out !== e_sw) begin
                bad++;
                $display("FAIL model sw_out cyc=%0d got %b want %b", cyc, sw_out, e_sw);
            end
            if (rise !== e_rise) begin
                bad++;
                $display("FAIL model rise cyc=%0d got %b want %b", cyc, rise, e_rise);
            end
            if (fall !== e_fall) begin
                bad++;
                $display("FAIL model fall cyc=%0d got %b want %b", cyc, fall, e_fall);
            end
            if (coin_drop !== e_cd) begin
                bad++;
                $display("FAIL model coin_drop cyc=%0d got %b want %b", cyc, coin_drop, e_cd);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        sw_in = 4'b0010;
        tick(3);
        chk("rst sw_out", 32'(sw_out), 0);
        chk("rst rise", 32'(rise), 0);
        chk("rst fall", 32'(fall), 0);
        chk("rst coin_drop", 32'(coin_drop), 0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("idle sw_out", 32'(sw_out), 0);
        end

        // clean press/release on channel 0
        sw_in[0] = 1'b1;
        tick(5); chk("press early", 32'(sw_out[0]), 0);
        tick(1); chk("press sw_out", 32'(sw_out[0]), 1); chk("press rise", 32'(rise[0]), 1);
        tick(1); chk("rise clears", 32'(rise[0]), 0); chk("press hold", 32'(sw_out[0]), 1);
        tick(5);
        sw_in[0] = 1'b0;
        tick(5); chk("release early", 32'(fall[0]), 0);
        tick(1); chk("release fall", 32'(fall[0]), 1); chk("release sw_out", 32'(sw_out[0]), 0);
        tick(3);

        // glitch of 3 cycles rejected, 4 cycles accepted
        sw_in[0] = 1'b1; tick(3); sw_in[0] = 1'b0;
        tick(10); chk("glitch3 sw_out", 32'(sw_out[0]), 0);
        sw_in[0] = 1'b1; tick(4); sw_in[0] = 1'b0;
        tick(2); chk("pulse4 sw_out", 32'(sw_out[0]), 1); chk("pulse4 rise", 32'(rise[0]), 1);
        tick(10);

        // inverted channel 1
        sw_in[1] = 1'b0;
        tick(5); chk("inv early", 32'(sw_out[1]), 0);
        tick(1); chk("inv active", 32'(sw_out[1]), 1);
        sw_in[1] = 1'b1;
        tick(6); chk("inv idle", 32'(sw_out[1]), 0);
        tick(2);

        // simultaneous channels 0 and 2
        sw_in[0] = 1'b1; sw_in[2] = 1'b1;
        tick(6); chk("simul rise", 32'(rise), 32'h5);
        sw_in[0] = 1'b0; sw_in[2] = 1'b0;
        tick(10);

        // coin held 50 cycles: one 3-cycle pulse
        sw_in[3] = 1'b1;
        tick(6); chk("coin rise", 32'(rise[3]), 1); chk("coin not yet", 32'(sw_out[3]), 0);
        tick(1); chk("coin p1", 32'(sw_out[3]), 1);
        tick(2); chk("coin p3", 32'(sw_out[3]), 1);
        tick(1); chk("coin end", 32'(sw_out[3]), 0);
        tick(40);
        sw_in[3] = 1'b0;
        tick(12);

        // second debounced press lands in final GAP cycle
        sw_in[3] = 1'b1; tick(4);
        sw_in[3] = 1'b0; tick(4);
        sw_in[3] = 1'b1; tick(4);
        sw_in[3] = 1'b0; tick(2);
        chk("gap drop", 32'(coin_drop[3]), 1);
        chk("gap rise", 32'(rise[3]), 1);
        chk("gap no pulse", 32'(sw_out[3]), 0);
        tick(1); chk("drop clears", 32'(coin_drop[3]), 0);
        tick(1); chk("no pulse after drop", 32'(sw_out[3]), 0);
        tick(15);

        // fresh press after lockout
        sw_in[3] = 1'b1;
        tick(7); chk("repress pulse", 32'(sw_out[3]), 1);
        tick(3); chk("repress end", 32'(sw_out[3]), 0);
        sw_in[3] = 1'b0;
        tick(20);

        // reset during second pulse cycle, pin still held
        sw_in[3] = 1'b1;
        tick(8); chk("pre-reset pulse", 32'(sw_out[3]), 1);
        reset = 1'b1;
        tick(1); chk("reset kills pulse", 32'(sw_out[3]), 0);
        reset = 1'b0;
        tick(5); chk("post-reset quiet", 32'(sw_out[3]), 0);
        tick(1); chk("post-reset rise", 32'(rise[3]), 1); chk("post-reset low", 32'(sw_out[3]), 0);
        tick(1); chk("post-reset pulse", 32'(sw_out[3]), 1);
        sw_in[3] = 1'b0;
        tick(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ff_input_cond.md
Name: ff_input_cond

Overview:
- Parametrised input conditioner for cabinet switches: coin, start, throw, test and service inputs.
- Sits between the raw switch pins and the ff core.
- Per channel: synchronises the input, applies a polarity mask, and debounces it with a programmable counter.
- Coin channels emit fixed-width, rate-limited pulses; all other channels give a debounced level plus one-cycle edge strobes.

Parameters:
- NCH, 10, number of input channels.
- CNT_W, 16, width of the debounce counters.
- DEBOUNCE, 12000, number of consecutive clk12m cycles an input must hold a new value before it is accepted (1 ms at 12 MHz). Legal range 1..2^CNT_W-1.
- INVERT, 0, NCH-bit mask; bit set = channel is active-low at the pin.
- COIN_MASK, 0, NCH-bit mask; bit set = channel runs in coin-pulse mode.
- COIN_PULSE, 6000, coin output high time in cycles (must be >=1).
- COIN_GAP, 12000, minimum low time after a coin pulse, in cycles (may be 0).
- PW_W, 16, width of the coin pulse/gap counters.

Ports:
- clk12m  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- sw_in  in  NCH  raw switch pins, asynchronous to clk12m.
- sw_out  out  NCH  conditioned active-high level. For coin channels this is the coin pulse.
- rise  out  NCH  one-cycle strobe when the debounced state goes 0->1.
- fall  out  NCH  one-cycle strobe when the debounced state goes 1->0.
- coin_drop  out  NCH  one-cycle strobe when a coin edge is discarded because of lockout; always 0 on non-coin channels.

Behaviour:
- Reset: every register is cleared, so sw_out, rise, fall and coin_drop are 0. This includes the sync flops, the stable state, all counters, and the coin FSMs (which return to IDLE).
- Reset takes effect at the next clk12m edge and aborts any debounce or coin pulse in progress. No pulse resumes after reset is released.
- Polarity: p = sw_in ^ INVERT. A channel with its INVERT bit set and its pin held high therefore reads inactive.
- Synchroniser: p passes through a 2-flop chain, sync1 then sync2.
- Debounce, per channel, with counter cnt and state stable:
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == DEBOUNCE-1: stable <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
- Latency: suppose a level change is first captured into sync1 at edge k. stable updates at edge k+1+DEBOUNCE. Any reversion before that edge clears cnt and produces no output change.
- Glitches: a pulse of fewer than DEBOUNCE sync2 cycles never reaches stable.
- Strobes: rise and fall are registered at the same edge at which stable changes. They are high for exactly one cycle and are never both high on one channel.
  - rise/fall are reported on coin channels too; they reflect the debounced switch, not the pulse.
- Level channels (COIN_MASK bit = 0): sw_out = stable.
- Coin channels (COIN_MASK bit = 1) use FSM IDLE -> PULSE -> GAP -> IDLE with a PW_W-bit counter pc:
  - IDLE: sw_out = 0. On rise: go to PULSE, pc <= 0, sw_out = 1 starting the next cycle.
  - PULSE: sw_out = 1 for exactly COIN_PULSE cycles. Then go to GAP, or straight to IDLE if COIN_GAP = 0.
  - GAP: sw_out = 0 for exactly COIN_GAP cycles, then IDLE.
  - A rise arriving while in PULSE or GAP (including the final GAP cycle) is discarded. coin_drop pulses for one cycle, coincident with that rise.
  - Holding the coin switch never lengthens the pulse.
  - A fall during PULSE does not shorten it.
- Channels are fully independent. Simultaneous events on different channels are all handled in the same cycle.
- Counters saturate nowhere. cnt wraps are prevented by the compare rule above.

Test Plan:
All tests use NCH=4, DEBOUNCE=4, COIN_PULSE=3, COIN_GAP=5, INVERT=4'b0010, COIN_MASK=4'b1000.
- Reset release: pins at 0 except sw_in[1]=1, reset held high 3 cycles then low -> sw_out, rise, fall and coin_drop all 0; sw_out stays 0 for 20 cycles.
- Clean press: sw_in[0] 0->1 captured at edge k -> sw_out[0]=1 and rise[0]=1 at edge k+5. rise[0] clears at k+6. Release gives fall[0] at the same relative latency.
- Glitch rejection: sw_in[0]=1 for 3 cycles, then 0 -> sw_out[0] and rise[0] stay 0. A 4-cycle pulse (measured at sync2) -> accepted.
- Inverted channel: sw_in[1] 1->0 -> sw_out[1] rises 5 edges after capture; sw_in[1]=1 -> low again.
- Coin pulse and lockout:
  - sw_in[3] held high 50 cycles -> sw_out[3] high exactly 3 cycles, starting 1 cycle after rise[3]. No further pulse.
  - A second debounced press landing in GAP -> coin_drop[3]=1 for 1 cycle and no pulse.
  - A press after GAP -> new 3-cycle pulse.
- Reset mid-pulse: assert reset during the 2nd PULSE cycle -> sw_out[3]=0 at the next edge. After release, no pulse occurs until a fresh debounced rise.
